// File: rtl/multicycle_control.sv
// Control FSM for the 16-bit multi-cycle processor: sequences fetch/decode/execute
// and drives the Calculations-stage selects plus PC, IR, memory and register-file enables.
module multicycle_control #(
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0001,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      input_IR,
  input  logic             input_Zero,
  output logic [3:0]       output_ALUOp,
  output logic [1:0]       output_ALUSrcA,
  output logic [1:0]       output_ALUSrcB,
  output logic             output_PCSrc,
  output logic             output_PCWrite,
  output logic             output_IRWrite,
  output logic             output_MemRead,
  output logic             output_MemWrite,
  output logic             output_RegWrite,
  output logic             output_MemtoReg,
  output logic             output_RegDst,
  output logic             output_IorD,
  output logic [3:0]       output_state,
  output logic             output_halted,
  output logic             output_illegal,
  output logic [CNT_W-1:0] output_instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic [3:0] aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       pcsrc;
    logic       pcwrite;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       halted;
  } ctrl_t;

  state_t          state_q, state_d;
  ctrl_t           ctrl_q;
  logic            armed_q;
  logic [CNT_W-1:0] count_q;
  logic            unused_ir;

  assign unused_ir = ^input_IR[11:4];

  // Output values for the state about to be entered; IR is stable across every
  // edge that leads into an IR-dependent state because IRWrite is only high in FETCH.
  function automatic ctrl_t ctrl_for(state_t s, logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.srcb    = 2'b01;
        c.aluop   = ALU_ADD;
      end
      S_DECODE: begin
        c.srcb  = 2'b10;
        c.aluop = ALU_ADD;
      end
      S_EXEC_R: begin
        c.srca  = 2'b10;
        c.aluop = ir[3:0];
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.srca  = 2'b10;
        c.srcb  = 2'b10;
        c.aluop = ALU_ADD;
      end
      S_ALU_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = (ir[15:12] == 4'd0);
      end
      S_MEM_RD: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      S_MEM_WB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEM_WR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_BRANCH: begin
        c.srca  = 2'b10;
        c.aluop = ALU_SUB;
        c.pcsrc = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc   = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (input_IR[15:12])
          4'd0:       state_d = S_EXEC_R;
          4'd1:       state_d = S_EXEC_I;
          4'd2, 4'd3: state_d = S_MEM_ADDR;
          4'd4, 4'd5: state_d = S_BRANCH;
          4'd6:       state_d = S_JUMP;
          4'd7:       state_d = S_HALT;
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (input_IR[15:12] == 4'd2) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_EXEC_R:   state_d = S_ALU_WB;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // The first edge after reset only arms the FSM so FETCH gets a full cycle with its enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= '0;
      armed_q <= 1'b0;
      count_q <= '0;
    end else if (!armed_q) begin
      armed_q <= 1'b1;
      ctrl_q  <= ctrl_for(S_FETCH, input_IR);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, input_IR);
      if (state_d == S_FETCH && state_q != S_FETCH)
        count_q <= count_q + CNT_W'(1);
    end
  end

  // beq (opcode 4) writes PC on Zero, bne (opcode 5) on ~Zero; opcode bit 12 tells them apart.
  assign output_PCWrite     = ctrl_q.pcwrite |
                              ((state_q == S_BRANCH) & (input_Zero ^ input_IR[12]));
  assign output_illegal     = (state_q == S_DECODE) & input_IR[15];
  assign output_ALUOp       = ctrl_q.aluop;
  assign output_ALUSrcA     = ctrl_q.srca;
  assign output_ALUSrcB     = ctrl_q.srcb;
  assign output_PCSrc       = ctrl_q.pcsrc;
  assign output_IRWrite     = ctrl_q.irwrite;
  assign output_MemRead     = ctrl_q.memread;
  assign output_MemWrite    = ctrl_q.memwrite;
  assign output_RegWrite    = ctrl_q.regwrite;
  assign output_MemtoReg    = ctrl_q.memtoreg;
  assign output_RegDst      = ctrl_q.regdst;
  assign output_IorD        = ctrl_q.iord;
  assign output_halted      = ctrl_q.halted;
  assign output_state       = state_q;
  assign output_instr_count = count_q;

endmodule
